stereo_gray_arbiter: RTL and testbench

//  Shares a single color2gray converter between the left and right camera streams of the stereo front end.

---
 rtl/stereo_gray_arbiter_pkg.sv | 25 ++
 rtl/stereo_gray_arbiter_color2gray.sv | 62 ++++++
 rtl/stereo_gray_arbiter.sv | 108 ++++++++++
 tb/tb_stereo_gray_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_gray_arbiter_pkg.sv
// Shared definitions for the stereo gray arbiter.
//   - ID_L / ID_R   : source identity carried alongside each pixel
//   - tag_t         : {v,id} descriptor tracking a pixel through the converter
//   - DEF_*         : default stream widths
//   - COEF_*        : luma weights used by the converter (sum = 256)
package stereo_gray_arbiter_pkg;

  localparam int DEF_INPUTDATAWID  = 25;
  localparam int DEF_OUTPUTDATAWID = 9;
  localparam int DEF_CONV_LAT      = 2;

  localparam logic ID_L = 1'b0;
  localparam logic ID_R = 1'b1;

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

  // Weights add up to 256, so R=G=B=x maps exactly back to x.
  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

endpackage

// File: rtl/stereo_gray_arbiter_color2gray.sv
// color2gray: two-stage RGB-to-gray converter.
//   clk_i       : pixel clock
//   en_i        : pipeline advance; when low every stage holds
//   pixel_en_i  : per-pixel qualifier, ANDed with en_i
//   stream_i    : {sof, R[7:0], G[7:0], B[7:0]}
//   stream_o    : {sof, gray[7:0]}, two enabled cycles after stream_i
// Data registers carry no reset; validity is tracked outside.
module color2gray
  import stereo_gray_arbiter_pkg::*;
#(
  parameter int INPUTDATAWID  = DEF_INPUTDATAWID,
  parameter int OUTPUTDATAWID = DEF_OUTPUTDATAWID
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     pixel_en_i,
  input  logic [INPUTDATAWID-1:0]  stream_i,
  output logic [OUTPUTDATAWID-1:0] stream_o
);

  // Round-half-up of the weighted sum back to 8 bits; max sum 65280
  // plus 128 still fits in 16 bits, so no saturation is needed.
  function automatic logic [7:0] round_gray(input logic [15:0] sum);
    logic [16:0] t;
    t = {1'b0, sum} + 17'd128;
    return 8'(t >> 8);
  endfunction

  logic        stage_en;
  logic [15:0] sum_d;
  logic [15:0] sum_p1_q;
  logic        sof_p1_q;
  logic [7:0]  gray_p2_q;
  logic        sof_p2_q;

  assign stage_en = en_i & pixel_en_i;

  always_comb begin
    sum_d = 16'(COEF_R) * 16'(stream_i[23:16])
          + 16'(COEF_G) * 16'(stream_i[15:8])
          + 16'(COEF_B) * 16'(stream_i[7:0]);
  end

  // Stage 1: weighted sum
  always_ff @(posedge clk_i) begin
    if (stage_en) begin
      sum_p1_q <= sum_d;
      sof_p1_q <= stream_i[INPUTDATAWID-1];
    end
  end

  // Stage 2: rounding to 8-bit gray
  always_ff @(posedge clk_i) begin
    if (stage_en) begin
      gray_p2_q <= round_gray(sum_p1_q);
      sof_p2_q  <= sof_p1_q;
    end
  end

  assign stream_o = OUTPUTDATAWID'({sof_p2_q, gray_p2_q});

endmodule

// File: rtl/stereo_gray_arbiter.sv
// stereo_gray_arbiter: shares one color2gray converter between the left and
// right camera streams.
//   clk, rst_n             : pixel clock, asynchronous active-low reset
//   run                    : 1 = grant new pixels, 0 = drain only
//   in_l_* / in_r_*        : {sof,rgb} valid/ready inputs
//   out_l_* / out_r_*      : {sof,gray} valid/ready outputs (shared data bus)
//   idle                   : nothing in flight inside the converter
// A {v,id} tag travels beside each pixel so results are steered back to the
// source port. Backpressure on the port owning the head result freezes the
// whole converter and blocks all grants.
module stereo_gray_arbiter
  import stereo_gray_arbiter_pkg::*;
#(
  parameter int INPUTDATAWID  = DEF_INPUTDATAWID,
  parameter int OUTPUTDATAWID = DEF_OUTPUTDATAWID,
  parameter int CONV_LAT      = DEF_CONV_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [INPUTDATAWID-1:0]  in_l_data,
  input  logic                     in_l_valid,
  output logic                     in_l_ready,
  input  logic [INPUTDATAWID-1:0]  in_r_data,
  input  logic                     in_r_valid,
  output logic                     in_r_ready,
  output logic [OUTPUTDATAWID-1:0] out_l_data,
  output logic                     out_l_valid,
  input  logic                     out_l_ready,
  output logic [OUTPUTDATAWID-1:0] out_r_data,
  output logic                     out_r_valid,
  input  logic                     out_r_ready,
  output logic                     idle
);

  // The tag pipeline is exactly two deep; any other latency is unsupported.
  if (CONV_LAT != 2) begin : g_lat_check
    $error("stereo_gray_arbiter: CONV_LAT must be 2");
  end

  tag_t tag1_q, tag1_d, tag2_q;
  logic rr_q;
  logic stall, adv, can_grant;
  logic grant_l, grant_r, accepted;
  logic [INPUTDATAWID-1:0]  conv_in;
  logic [OUTPUTDATAWID-1:0] conv_out;

  assign stall = tag2_q.v & ~((tag2_q.id == ID_R) ? out_r_ready : out_l_ready);
  assign adv   = ~stall;

  // rst_n gates the grant so no ready is ever shown while held in reset.
  assign can_grant = run & adv & rst_n;

  // rr_q holds the last granted id; on a tie the other source wins.
  always_comb begin
    grant_l = can_grant & in_l_valid & (~in_r_valid | (rr_q == ID_R));
    grant_r = can_grant & in_r_valid & (~in_l_valid | (rr_q == ID_L));
  end

  assign accepted   = grant_l | grant_r;
  assign in_l_ready = grant_l;
  assign in_r_ready = grant_r;

  always_comb begin
    conv_in = '0;
    if (grant_l)      conv_in = in_l_data;
    else if (grant_r) conv_in = in_r_data;
  end

  // An empty slot enters as a bubble so the pipeline drains when unstalled.
  always_comb begin
    tag1_d    = '0;
    tag1_d.v  = accepted;
    tag1_d.id = grant_r ? ID_R : ID_L;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_q <= '0;
      tag2_q <= '0;
      rr_q   <= ID_R;
    end else begin
      if (adv) begin
        tag1_q <= tag1_d;
        tag2_q <= tag1_q;
      end
      if (accepted) rr_q <= tag1_d.id;
    end
  end

  color2gray #(
    .INPUTDATAWID  (INPUTDATAWID),
    .OUTPUTDATAWID (OUTPUTDATAWID)
  ) u_conv (
    .clk_i      (clk),
    .en_i       (adv),
    .pixel_en_i (1'b1),
    .stream_i   (conv_in),
    .stream_o   (conv_out)
  );

  assign out_l_valid = tag2_q.v & (tag2_q.id == ID_L);
  assign out_r_valid = tag2_q.v & (tag2_q.id == ID_R);
  assign out_l_data  = conv_out;
  assign out_r_data  = conv_out;
  assign idle        = ~tag1_q.v & ~tag2_q.v;

endmodule

// File: tb/tb_stereo_gray_arbiter.sv
module tb_stereo_gray_arbiter;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [24:0] in_l_data;
  logic        in_l_valid;
  logic        in_l_ready;
  logic [24:0] in_r_data;
  logic        in_r_valid;
  logic        in_r_ready;
  logic [8:0]  out_l_data;
  logic        out_l_valid;
  logic        out_l_ready;
  logic [8:0]  out_r_data;
  logic        out_r_valid;
  logic        out_r_ready;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  stereo_gray_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .in_l_data   (in_l_data),
    .in_l_valid  (in_l_valid),
    .in_l_ready  (in_l_ready),
    .in_r_data   (in_r_data),
    .in_r_valid  (in_r_valid),
    .in_r_ready  (in_r_ready),
    .out_l_data  (out_l_data),
    .out_l_valid (out_l_valid),
    .out_l_ready (out_l_ready),
    .out_r_data  (out_r_data),
    .out_r_valid (out_r_valid),
    .out_r_ready (out_r_ready),
    .idle        (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  function automatic logic [24:0] pix(input logic sof, input logic [7:0] g);
    return {sof, g, g, g};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    run         = 1'b1;
    in_l_valid  = 1'b1;
    in_l_data   = pix(1'b0, 8'd1);
    in_r_valid  = 1'b0;
    in_r_data   = '0;
    out_l_ready = 1'b1;
    out_r_ready = 1'b1;

    // Reset state
    #2;
    chk1("rst_out_l_valid", out_l_valid, 1'b0);
    chk1("rst_out_r_valid", out_r_valid, 1'b0);
    chk1("rst_idle", idle, 1'b1);
    chk1("rst_in_l_ready", in_l_ready, 1'b0);
    in_l_valid = 1'b0;
    #10 rst_n = 1'b1;

    // 1: left only, four gray-100 pixels
    for (int k = 0; k < 8; k++) begin
      tick();
      in_l_valid = (k < 4);
      in_l_data  = pix(1'b0, 8'd100);
      #2;
      chk1("t1_l_ready", in_l_ready, (k < 4));
      chk1("t1_out_l_valid", out_l_valid, (k >= 2 && k < 6));
      if (k >= 2 && k < 6) chk9("t1_out_l_data", out_l_data, 9'd100);
      chk1("t1_out_r_valid", out_r_valid, 1'b0);
    end

    // 2: both valid after reset, L first, alternating
    tick(); rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    in_l_valid = 1'b1; in_l_data = pix(1'b0, 8'd10);
    in_r_valid = 1'b1; in_r_data = pix(1'b0, 8'd20);
    #2;
    chk1("t2_k0_l_ready", in_l_ready, 1'b1);
    chk1("t2_k0_r_ready", in_r_ready, 1'b0);
    tick(); in_l_data = pix(1'b0, 8'd30); #2;
    chk1("t2_k1_l_ready", in_l_ready, 1'b0);
    chk1("t2_k1_r_ready", in_r_ready, 1'b1);
    tick(); in_r_data = pix(1'b0, 8'd40); #2;
    chk1("t2_k2_l_ready", in_l_ready, 1'b1);
    chk1("t2_k2_out_l_valid", out_l_valid, 1'b1);
    chk9("t2_k2_out_l_data", out_l_data, 9'd10);
    tick(); in_l_valid = 1'b0; #2;
    chk1("t2_k3_r_ready", in_r_ready, 1'b1);
    chk1("t2_k3_out_r_valid", out_r_valid, 1'b1);
    chk1("t2_k3_out_l_valid", out_l_valid, 1'b0);
    chk9("t2_k3_out_r_data", out_r_data, 9'd20);
    tick(); in_r_valid = 1'b0; #2;
    chk1("t2_k4_out_l_valid", out_l_valid, 1'b1);
    chk9("t2_k4_out_l_data", out_l_data, 9'd30);
    tick(); #2;
    chk1("t2_k5_out_r_valid", out_r_valid, 1'b1);
    chk9("t2_k5_out_r_data", out_r_data, 9'd40);
    tick(); #2;
    chk1("t2_k6_idle", idle, 1'b1);

    // 3: right output backpressure with an R result at the head
    tick();
    out_r_ready = 1'b0;
    in_l_valid = 1'b1; in_l_data = pix(1'b0, 8'd50);
    in_r_valid = 1'b1; in_r_data = pix(1'b0, 8'd60);
    #2;
    chk1("t3_m0_l_ready", in_l_ready, 1'b1);
    tick(); in_l_data = pix(1'b0, 8'd70); #2;
    chk1("t3_m1_r_ready", in_r_ready, 1'b1);
    tick(); in_r_valid = 1'b0; #2;
    chk1("t3_m2_l_ready", in_l_ready, 1'b1);
    chk9("t3_m2_out_l_data", out_l_data, 9'd50);
    tick(); in_l_data = pix(1'b0, 8'd90); #2;
    chk1("t3_m3_out_r_valid", out_r_valid, 1'b1);
    chk9("t3_m3_out_r_data", out_r_data, 9'd60);
    chk1("t3_m3_l_ready", in_l_ready, 1'b0);
    chk1("t3_m3_out_l_valid", out_l_valid, 1'b0);
    tick(); #2;
    chk1("t3_m4_out_r_valid", out_r_valid, 1'b1);
    chk9("t3_m4_out_r_data", out_r_data, 9'd60);
    chk1("t3_m4_l_ready", in_l_ready, 1'b0);
    tick(); out_r_ready = 1'b1; #2;
    chk1("t3_m5_out_r_valid", out_r_valid, 1'b1);
    chk9("t3_m5_out_r_data", out_r_data, 9'd60);
    chk1("t3_m5_l_ready", in_l_ready, 1'b1);
    tick(); in_l_valid = 1'b0; #2;
    chk1("t3_m6_out_l_valid", out_l_valid, 1'b1);
    chk9("t3_m6_out_l_data", out_l_data, 9'd70);
    tick(); #2;
    chk9("t3_m7_out_l_data", out_l_data, 9'd90);
    chk1("t3_m7_out_r_valid", out_r_valid, 1'b0);
    tick();

    // 4: sof on left pixel 0 and right pixel 5; right alone gets every cycle
    tick();
    in_l_valid = 1'b1; in_l_data = pix(1'b1, 8'd5);
    #2;
    chk1("t4_l_ready", in_l_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      in_l_valid = 1'b0;
      in_r_valid = (k < 6);
      in_r_data  = pix((k == 5), 8'(k * 10 + 1));
      #2;
      chk1("t4_r_ready", in_r_ready, (k < 6));
      chk1("t4_out_l_valid", out_l_valid, (k == 1));
      if (k == 1) chk9("t4_out_l_data", out_l_data, 9'h105);
      chk1("t4_out_r_valid", out_r_valid, (k >= 2));
      if (k >= 2) chk9("t4_out_r_data", out_r_data, {((k - 2) == 5), 8'((k - 2) * 10 + 1)});
    end

    // 5: run dropped with two colored pixels in flight
    tick();
    in_r_valid = 1'b0;
    tick();
    in_l_valid = 1'b1; in_l_data = 25'h0FF0000;
    in_r_valid = 1'b1; in_r_data = 25'h000FF00;
    #2;
    chk1("t5_c0_l_ready", in_l_ready, 1'b1);
    tick(); in_l_valid = 1'b0; #2;
    chk1("t5_c1_r_ready", in_r_ready, 1'b1);
    tick();
    run = 1'b0;
    in_l_valid = 1'b1; in_l_data = pix(1'b0, 8'd7);
    in_r_valid = 1'b1; in_r_data = pix(1'b0, 8'd8);
    #2;
    chk1("t5_c2_l_ready", in_l_ready, 1'b0);
    chk1("t5_c2_r_ready", in_r_ready, 1'b0);
    chk1("t5_c2_out_l_valid", out_l_valid, 1'b1);
    chk9("t5_c2_out_l_data", out_l_data, 9'd77);
    chk1("t5_c2_idle", idle, 1'b0);
    tick(); #2;
    chk1("t5_c3_r_ready", in_r_ready, 1'b0);
    chk1("t5_c3_out_r_valid", out_r_valid, 1'b1);
    chk9("t5_c3_out_r_data", out_r_data, 9'd149);
    chk1("t5_c3_idle", idle, 1'b0);
    tick(); #2;
    chk1("t5_c4_idle", idle, 1'b1);
    chk1("t5_c4_l_ready", in_l_ready, 1'b0);
    chk1("t5_c4_out_l_valid", out_l_valid, 1'b0);
    chk1("t5_c4_out_r_valid", out_r_valid, 1'b0);

    // 6: asynchronous reset with both tags valid
    tick();
    run = 1'b1;
    in_l_valid = 1'b1; in_l_data = pix(1'b0, 8'd33);
    in_r_valid = 1'b0;
    #2;
    chk1("t6_d0_l_ready", in_l_ready, 1'b1);
    tick(); in_l_data = pix(1'b0, 8'd34); #2;
    chk1("t6_d1_l_ready", in_l_ready, 1'b1);
    tick(); in_l_valid = 1'b0; #2;
    chk1("t6_d2_idle", idle, 1'b0);
    chk1("t6_d2_out_l_valid", out_l_valid, 1'b1);
    in_l_valid = 1'b1; in_l_data = pix(1'b0, 8'd44);
    in_r_valid = 1'b1; in_r_data = pix(1'b0, 8'd45);
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_out_l_valid", out_l_valid, 1'b0);
    chk1("t6_rst_idle", idle, 1'b1);
    chk1("t6_rst_l_ready", in_l_ready, 1'b0);
    chk1("t6_rst_r_ready", in_r_ready, 1'b0);
    tick();
    #2 rst_n = 1'b1;
    #1;
    chk1("t6_post_l_ready", in_l_ready, 1'b1);
    chk1("t6_post_r_ready", in_r_ready, 1'b0);
    tick(); in_l_valid = 1'b0; in_r_valid = 1'b0;
    tick(); #2;
    chk1("t6_post_out_l_valid", out_l_valid, 1'b1);
    chk9("t6_post_out_l_data", out_l_data, 9'd44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
